// File: rtl/ttt_pkg.sv
// ttt_pkg: shared cell codes, board geometry, FSM states and line lookup for the computer player
package ttt_pkg;
   localparam logic [1:0] CELL_EMPTY    = 2'b00;
   localparam logic [1:0] CELL_PLAYER   = 2'b01;
   localparam logic [1:0] CELL_COMPUTER = 2'b10;
   localparam int NUM_CELLS = 16;
   localparam int NUM_LINES = 10;
   typedef enum logic [2:0] {
      S_IDLE,
      S_SCAN_WIN,
      S_SCAN_BLOCK,
      S_SCAN_FREE,
      S_ISSUE,
      S_NO_MOVE
   } state_t;
   // k 0..3 rows {r,m}, 4..7 columns {m,c}, 8 diagonal 5m, 9 anti-diagonal 3+3m == {m,~m}
   function automatic logic [3:0] line_cell(input logic [3:0] k, input logic [1:0] m);
      return (k < 4'd4) ? {k[1:0], m} : (k < 4'd8) ? {m, k[1:0]} : (k == 4'd8) ? {m, m} : {m, ~m};
   endfunction
endpackage

// File: rtl/ttt_computer_player_lfsr.sv
// ttt_lfsr4: 4-bit x^4+x^3+1 LFSR, free-running while reset is high
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, loads seed
//   seed  : nonzero reset value
//   value : current LFSR state, cycles through 1..15
module ttt_lfsr4 (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] seed,
   output logic [3:0] value
);
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) value <= seed;
      else value <= {value[2:0], value[3] ^ value[2]};
   end
endmodule

// File: rtl/ttt_computer_player.sv
// ttt_computer_player: picks a 4x4 tic-tac-toe move (win, then block, then free cell) and strobes it to the game
//   clock             : rising-edge clock
//   reset             : asynchronous active-low reset
//   board             : cell i at [2i+1:2i]; 00 empty, 01 player, 10 computer, 11 occupied
//   turn_req          : move request, sampled only while idle
//   game_over         : blocks new moves and aborts scans
//   computer_position : chosen cell, held until the next move
//   pc                : move strobe, high PC_HOLD_CYCLES cycles
//   busy              : high whenever not idle
//   no_move           : one-cycle pulse when the board has no empty cell
// Build option: TTT_CPU_BLOCK_EN enables the blocking-move scan pass.
module ttt_computer_player
   import ttt_pkg::*;
#(
   parameter int         PC_HOLD_CYCLES = 5,
   parameter logic [3:0] LFSR_SEED      = 4'h1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] board,
   input  logic        turn_req,
   input  logic        game_over,
   output logic [3:0]  computer_position,
   output logic        pc,
   output logic        busy,
   output logic        no_move
);
   localparam int CW = $clog2(PC_HOLD_CYCLES + 1);
   localparam logic [CW-1:0] HOLD = CW'(PC_HOLD_CYCLES);
`ifdef TTT_CPU_BLOCK_EN
   localparam state_t AFTER_WIN = S_SCAN_BLOCK;
`else
   localparam state_t AFTER_WIN = S_SCAN_FREE;
`endif
   state_t state, state_n;
   logic [3:0] idx, idx_n, start, start_n, tgt, tgt_n, pos_n, lfsr;
   logic [31:0] snap, snap_n;
   logic [CW-1:0] cnt, cnt_n;
   logic pc_n, nm_n;
   logic [1:0] want, cv;
   logic [2:0] n_want, n_empty;
   logic [3:0] hole, lc, free_cell;
   logic line_hit, free_hit;
   ttt_lfsr4 u_lfsr (
      .clock(clock),
      .reset(reset),
      .seed (LFSR_SEED),
      .value(lfsr)
   );
   assign busy = state != S_IDLE;
   // hit needs exactly three of the wanted mark and one empty; hole ends up as that empty cell
   always_comb begin
      want = (state == S_SCAN_WIN) ? CELL_COMPUTER : CELL_PLAYER;
      n_want = '0;
      n_empty = '0;
      hole = '0;
      lc = '0;
      cv = '0;
      for (int m = 0; m < 4; m++) begin
         lc = line_cell(idx, 2'(m));
         cv = snap[{lc, 1'b0} +: 2];
         n_want = n_want + {2'b00, cv == want};
         n_empty = n_empty + {2'b00, cv == CELL_EMPTY};
         hole = (cv == CELL_EMPTY) ? lc : hole;
      end
   end
   assign line_hit  = n_want == 3'd3 && n_empty == 3'd1;
   assign free_cell = start + idx;
   assign free_hit  = snap[{free_cell, 1'b0} +: 2] == CELL_EMPTY;
   always_comb begin
      state_n = state;
      idx_n = idx;
      snap_n = snap;
      start_n = start;
      tgt_n = tgt;
      cnt_n = cnt;
      pos_n = computer_position;
      pc_n = 1'b0;
      nm_n = 1'b0;
      case (state)
         S_IDLE: begin
            if (turn_req && !game_over) begin
               state_n = S_SCAN_WIN;
               idx_n = '0;
               snap_n = board;
               start_n = lfsr;
            end
         end
         S_SCAN_WIN, S_SCAN_BLOCK: begin
            if (game_over) state_n = S_IDLE;
            else if (line_hit) begin
               tgt_n = hole;
               cnt_n = '0;
               state_n = S_ISSUE;
            end else if (idx == 4'(NUM_LINES - 1)) begin
               idx_n = '0;
               state_n = (state == S_SCAN_WIN) ? AFTER_WIN : S_SCAN_FREE;
            end else idx_n = idx + 4'd1;
         end
         S_SCAN_FREE: begin
            if (game_over) state_n = S_IDLE;
            else if (free_hit) begin
               tgt_n = free_cell;
               cnt_n = '0;
               state_n = S_ISSUE;
            end else if (idx == 4'(NUM_CELLS - 1)) state_n = S_NO_MOVE;
            else idx_n = idx + 4'd1;
         end
         // game_over is deliberately not looked at here so an accepted move is never cut short
         S_ISSUE: begin
            pos_n = tgt;
            pc_n = cnt != HOLD;
            cnt_n = cnt + 1'b1;
            state_n = (cnt == HOLD) ? S_IDLE : S_ISSUE;
         end
         S_NO_MOVE: begin
            nm_n = 1'b1;
            state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         idx <= '0;
         snap <= '0;
         start <= '0;
         tgt <= '0;
         cnt <= '0;
         computer_position <= '0;
         pc <= 1'b0;
         no_move <= 1'b0;
      end else begin
         state <= state_n;
         idx <= idx_n;
         snap <= snap_n;
         start <= start_n;
         tgt <= tgt_n;
         cnt <= cnt_n;
         computer_position <= pos_n;
         pc <= pc_n;
         no_move <= nm_n;
      end
   end
endmodule

// File: tb/tb_ttt_computer_player.sv
// tb_ttt_computer_player: directed vector and sequence checks of the computer move generator
module tb_ttt_computer_player;
`ifdef TTT_CPU_BLOCK_EN
   localparam int FREE0 = 22;
   localparam int BLK_LAT = 12;
`else
   localparam int FREE0 = 12;
   localparam int BLK_LAT = 14;
`endif
   logic clock = 1'b0, reset = 1'b1, turn_req = 1'b0, game_over = 1'b0;
   logic [31:0] board = '0;
   logic [3:0] computer_position;
   logic pc, busy, no_move;
   int total = 0, bad = 0;
   ttt_computer_player dut (
      .clock(clock),
      .reset(reset),
      .board(board),
      .turn_req(turn_req),
      .game_over(game_over),
      .computer_position(computer_position),
      .pc(pc),
      .busy(busy),
      .no_move(no_move)
   );
   always #5 clock = ~clock;
   typedef struct {
      logic [15:0] cm;
      logic [15:0] pm;
      logic [15:0] xm;
      int pos;
      int lat;
      bit nm;
   } vec_t;
   vec_t vecs[9];
   function automatic logic [31:0] mk(input logic [15:0] cm, input logic [15:0] pm, input logic [15:0] xm);
      logic [31:0] b;
      b = '0;
      for (int i = 0; i < 16; i++) b[2*i +: 2] = xm[i] ? 2'b11 : cm[i] ? 2'b10 : pm[i] ? 2'b01 : 2'b00;
      return b;
   endfunction
   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic do_reset();
      @(posedge clock);
      #1 reset = 1'b0;
      turn_req = 1'b0;
      game_over = 1'b0;
      @(posedge clock);
      #1 reset = 1'b1;
   endtask
   task automatic wait_evt(output int lat, output bit saw_pc, output bit saw_nm);
      lat = 0;
      saw_pc = 1'b0;
      saw_nm = 1'b0;
      for (int n = 1; n <= 60 && lat == 0; n++) begin
         @(posedge clock);
         #1;
         if (pc || no_move) begin
            lat = n;
            saw_pc = pc;
            saw_nm = no_move;
         end
      end
   endtask
   task automatic pc_width(output int h);
      h = 1;
      for (int n = 0; n < 20 && pc; n++) begin
         @(posedge clock);
         #1;
         if (pc) h++;
      end
   endtask
   task automatic start_move(input logic [31:0] b, input bit hold);
      do_reset();
      board = b;
      turn_req = 1'b1;
      @(posedge clock);
      #1 turn_req = hold;
   endtask
   initial begin
      int lat, h;
      bit sp, sn;
      vecs[0] = '{16'h0700, 16'h0007, 16'h0000, 11, 4, 1'b0};
      vecs[1] = '{16'h0030, 16'h0007, 16'h0000, 3, BLK_LAT, 1'b0};
      vecs[2] = '{16'h0000, 16'h0000, 16'h0000, 1, FREE0, 1'b0};
      vecs[3] = '{16'h2022, 16'h0000, 16'h0000, 9, 7, 1'b0};
      vecs[4] = '{16'h1048, 16'h0000, 16'h0000, 9, 11, 1'b0};
      vecs[5] = '{16'h8131, 16'h0000, 16'h0000, 12, 6, 1'b0};
      vecs[6] = '{16'h0007, 16'h0008, 16'h0000, 4, FREE0 + 3, 1'b0};
      vecs[7] = '{16'h0000, 16'h0000, 16'h0072, 2, FREE0 + 1, 1'b0};
      vecs[8] = '{16'h5A5A, 16'hA5A5, 16'h0000, 0, FREE0 + 15, 1'b1};
      #2 reset = 1'b0;
      #1;
      chk("rst_pos", computer_position, 0);
      chk("rst_pc", pc, 0);
      chk("rst_busy", busy, 0);
      chk("rst_nm", no_move, 0);
      for (int i = 0; i < 9; i++) begin
         start_move(mk(vecs[i].cm, vecs[i].pm, vecs[i].xm), 1'b0);
         board = 32'hAAAAAAAA;
         chk($sformatf("v%0d_busy", i), busy, 1);
         wait_evt(lat, sp, sn);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
         if (vecs[i].nm) begin
            chk($sformatf("v%0d_pc", i), sp, 0);
            chk($sformatf("v%0d_nm", i), sn, 1);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
            @(posedge clock);
            #1 chk($sformatf("v%0d_nm_pulse", i), no_move, 0);
         end else begin
            chk($sformatf("v%0d_pos", i), computer_position, vecs[i].pos);
            pc_width(h);
            chk($sformatf("v%0d_width", i), h, 5);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
            chk($sformatf("v%0d_pos_hold", i), computer_position, vecs[i].pos);
         end
      end
      start_move(32'h0, 1'b0);
      repeat (3) @(posedge clock);
      #1 game_over = 1'b1;
      chk("abort_busy_before", busy, 1);
      @(posedge clock);
      #1 chk("abort_idle", busy, 0);
      game_over = 1'b0;
      wait_evt(lat, sp, sn);
      chk("abort_no_pc", lat, 0);
      do_reset();
      turn_req = 1'b1;
      game_over = 1'b1;
      repeat (2) @(posedge clock);
      #1 chk("gameover_idle_block", busy, 0);
      turn_req = 1'b0;
      game_over = 1'b0;
      start_move(mk(16'h0700, 16'h0007, 16'h0), 1'b0);
      wait_evt(lat, sp, sn);
      game_over = 1'b1;
      pc_width(h);
      chk("go_issue_width", h, 5);
      game_over = 1'b0;
      start_move(mk(16'h0700, 16'h0007, 16'h0), 1'b0);
      wait_evt(lat, sp, sn);
      chk("rst_issue_pc_before", pc, 1);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("rst_issue_pc", pc, 0);
      chk("rst_issue_pos", computer_position, 0);
      chk("rst_issue_busy", busy, 0);
      #1 reset = 1'b1;
      wait_evt(lat, sp, sn);
      chk("rst_issue_dropped", lat, 0);
      start_move(32'h0, 1'b1);
      wait_evt(lat, sp, sn);
      chk("held_lat1", lat, FREE0);
      chk("held_pos1", computer_position, 1);
      pc_width(h);
      chk("held_width1", h, 5);
      chk("held_busy_drop", busy, 0);
      @(posedge clock);
      #1 chk("held_restart", busy, 1);
      turn_req = 1'b0;
      wait_evt(lat, sp, sn);
      chk("held_lat2", lat, FREE0);
      chk("held_pos2", computer_position, (FREE0 == 22) ? 12 : 9);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ttt_computer_player.md
Name: ttt_computer_player

Overview:
- Upstream move generator for tic_tac_toe_game on the 4x4 board. It drives the game's computer_position and pc inputs.
- On a turn request it snapshots the board and scans lines for a winning move, then a blocking move. Failing both, it takes the first free cell from a pseudo-random start.
- It then presents the chosen cell with pc held high long enough for the game to accept it.

Parameters:
- PC_HOLD_CYCLES, 5, number of clock cycles pc stays high per move (min 1).
- LFSR_SEED, 4'h1, reset value of the 4-bit LFSR (must be nonzero).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- board  input  32  cell i at bits [2i+1:2i]; 00 empty, 01 player, 10 computer, 11 treated as occupied.
- turn_req  input  1  request a computer move; sampled only in IDLE.
- game_over  input  1  game decided (who != 0); blocks and aborts moves.
- computer_position  output  4  chosen cell index 0..15.
- pc  output  1  move strobe to the game.
- busy  output  1  high in every state except IDLE.
- no_move  output  1  one-cycle pulse when the board has no empty cell.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, computer_position=0, pc=0, busy=0, no_move=0, LFSR=LFSR_SEED. Reset mid-operation drops any pending move immediately.
- LFSR: x^4+x^3+1, advances every clock while reset=1. Its value is 1..15.
- Line table, index k:
  - k=0..3: row r = cells 4r..4r+3.
  - k=4..7: column c = cells c, c+4, c+8, c+12.
  - k=8: diagonal 0, 5, 10, 15.
  - k=9: anti-diagonal 3, 6, 9, 12.
- FSM IDLE: at edge E0 with turn_req=1 and game_over=0:
  - latch board into snap;
  - latch the pre-advance LFSR value into start;
  - busy=1, go to SCAN_WIN with k=0.
- SCAN_WIN: one line per cycle, k=0..9.
  - Hit: exactly 3 computer cells and 1 empty cell. Target is the empty cell; go to ISSUE.
  - After k=9 with no hit, go to SCAN_BLOCK.
- SCAN_BLOCK: same scan; hit is 3 player cells and 1 empty cell. Go to ISSUE on hit, else to SCAN_FREE.
- SCAN_FREE: one cell per cycle, cell (start+j) mod 16 for j=0..15.
  - First empty cell is the target; go to ISSUE.
  - After j=15 with no empty cell: no_move=1 for one cycle, then IDLE with pc never asserted.
- ISSUE: computer_position registered with the target; pc=1 from the same edge, held for exactly PC_HOLD_CYCLES cycles; then IDLE with busy=0.
- computer_position holds its value until the next ISSUE.
- Latency (edge at which pc rises, relative to E0):
  - win hit on line k: E0+k+2;
  - block hit on line k: E0+12+k;
  - free hit at step j: E0+22+j.
- Only the snapshot is evaluated; board changes during a scan are ignored.
- turn_req while busy is ignored; it is not queued.
- game_over=1 in any SCAN state aborts to IDLE next edge with no pc.
- game_over rising during ISSUE does not shorten pc.
- Priority: win > block > free. Within a pass, the lowest k (or lowest j) wins.

Optional Feature:
- Macro TTT_CPU_BLOCK_EN.
- Defined: SCAN_BLOCK pass is present as above.
- Undefined: SCAN_WIN goes directly to SCAN_FREE, and free-hit latency becomes E0+12+j.

Decomposition:
- Package ttt_pkg holds:
  - CELL_EMPTY/CELL_PLAYER/CELL_COMPUTER 2-bit constants;
  - NUM_CELLS=16, NUM_LINES=10;
  - FSM state enum;
  - function line_cell(k, m) returning cell index m (0..3) of line k.
- Sub-module ttt_lfsr4 (clock, reset, seed, value), instantiated once.

Test Plan:
- Win beats block: computer at 8,9,10; player at 0,1,2; turn_req -> pc rises at E0+4, computer_position=11, pc high 5 cycles, busy low after.
- Block: player 0,1,2; computer 4,5 -> computer_position=3 at E0+12 (macro defined); macro undefined -> cell chosen by free pass instead.
- Free pass from seed: empty board, turn_req on first edge after reset release -> start=1, computer_position=1 at E0+22.
- Full board (alternating 01/10, no lines) -> no_move pulse at E0+37, pc stays 0, busy drops.
- Abort and reset: game_over asserted at E0+3 -> no pc, IDLE at E0+4. Separately, reset pulled low during ISSUE -> pc=0 and computer_position=0 immediately.
- turn_req held high throughout a move -> exactly one move issued; a second move begins only after return to IDLE.
